ram_port_arbiter: RTL and testbench

//  Shares the single-port main RAM between two masters: port 0 (processor memory path)
//  and port 1 (program loader / DMA I/O engine).

---
 rtl/definitions_pkg.sv | 18 +
 rtl/arb_hold_counter.sv | 35 +++
 rtl/ram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared definitions for the main-RAM port arbiter: FSM state encoding,
// port count and hold-counter sizing.
package definitions_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_e;

  localparam int ARB_PORTS = 2;

  // A zero hold limit means unlimited ownership, but the counter still needs one bit.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of transactions executed during the current ownership;
// flags the transaction that reaches the hold limit.
module arb_hold_counter
  import definitions_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic limit_hit
);

  localparam int CNT_W = hold_cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] SAT_VAL  = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] LAST_VAL = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != SAT_VAL)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Also true once saturated, so a late-arriving request is still served at the limit.
  assign limit_hit = (MAX_HOLD != 0) && inc && (cnt_q >= LAST_VAL);

endmodule

// File: rtl/ram_port_arbiter.sv
// Registered-grant round-robin arbiter sharing the single-port main RAM between the
// processor path (port 0) and the loader/DMA engine (port 1), with bounded hold time.
module ram_port_arbiter
  import definitions_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  arb_state_e           state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic                 txn0, txn1;
  logic                 limit_hit;
  logic [ARB_PORTS-1:0] rvalid_q;

  assign m0_gnt = (state_q == ARB_OWN0);
  assign m1_gnt = (state_q == ARB_OWN1);
  assign txn0   = m0_gnt && m0_req;
  assign txn1   = m1_gnt && m1_req;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_d != state_q),
    .inc       (txn0 || txn1),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_owner_q ? ARB_OWN0 : ARB_OWN1;
        end else if (m0_req) begin
          state_d = ARB_OWN0;
        end else if (m1_req) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0_req) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b0;
        end else if (limit_hit && m1_req) begin
          state_d      = ARB_OWN1;
          last_owner_d = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!m1_req) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b1;
        end else if (limit_hit && m0_req) begin
          state_d      = ARB_OWN0;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ram_addr    = '0;
    ram_data_in = '0;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    if (txn0) begin
      ram_addr    = m0_addr;
      ram_data_in = m0_wdata;
      ram_wr_en   = m0_we;
      ram_rd_en   = !m0_we;
    end else if (txn1) begin
      ram_addr    = m1_addr;
      ram_data_in = m1_wdata;
      ram_wr_en   = m1_we;
      ram_rd_en   = !m1_we;
    end
  end

  // Read valid follows the issuing port, not the current owner, so a read in the
  // last owned cycle is still delivered after the grant moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= {txn1 && !m1_we, txn0 && !m0_we};
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign rdata     = (|rvalid_q) ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a behavioural RAM and
// a reference memory with a read-data scoreboard.
module tb_ram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_wr_en, ram_rd_en;
  logic [DW-1:0] ram_data_out;

  ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_HOLD   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .rdata        (rdata),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read and a preload port.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_wr_en) ram_mem[ram_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= ram_mem[ram_addr];
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  int            rv_count [2] = '{0, 0};
  int            rv_start;

  function automatic logic [DW-1:0] init_val(input int a);
    return 16'((a * 945) ^ 50010);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Per-cycle protocol checks and scoreboard; called mid low-phase of the clock.
  task automatic monitor();
    logic          e0, e1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    sb_t           item;
    if (reset) begin
      sb.delete();
      return;
    end
    e0 = m0_gnt && m0_req;
    e1 = m1_gnt && m1_req;
    ea = e0 ? m0_addr : (e1 ? m1_addr : '0);
    ed = e0 ? m0_wdata : (e1 ? m1_wdata : '0);
    check("gnt_exclusive", 32'(m0_gnt && m1_gnt), 32'(0));
    check("rd_wr_exclusive", 32'(ram_wr_en && ram_rd_en), 32'(0));
    check("ram_wr_en", 32'(ram_wr_en), 32'((e0 && m0_we) || (e1 && m1_we)));
    check("ram_rd_en", 32'(ram_rd_en), 32'((e0 && !m0_we) || (e1 && !m1_we)));
    check("ram_addr", 32'(ram_addr), 32'(ea));
    check("ram_data_in", 32'(ram_data_in), 32'(ed));
    if (m0_rvalid || m1_rvalid) begin
      check("rvalid_exclusive", 32'(m0_rvalid && m1_rvalid), 32'(0));
      check("rvalid_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        item = sb.pop_front();
        check("rvalid_port", 32'(m1_rvalid), 32'(item.port));
        check("rdata", 32'(rdata), 32'(item.data));
      end
      rv_count[m1_rvalid ? 1 : 0]++;
    end
    check("rvalid_missing", 32'(sb.size()), 32'(0));
    if ((e0 && !m0_we) || (e1 && !m1_we)) sb.push_back('{port: e1, data: ref_mem[ea]});
    if ((e0 && m0_we) || (e1 && m1_we)) ref_mem[ea] = ed;
  endtask

  task automatic cycle();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Preload the low 1 KiW of RAM while the arbiter is held in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = AW'(i);
      pre_data = init_val(i);
      ref_mem[i] = init_val(i);
    end
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    check("rst_m0_gnt", 32'(m0_gnt), 32'(0));
    check("rst_m1_gnt", 32'(m1_gnt), 32'(0));
    check("rst_m0_rvalid", 32'(m0_rvalid), 32'(0));
    check("rst_m1_rvalid", 32'(m1_rvalid), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_ram_en", 32'({ram_wr_en, ram_rd_en}), 32'(0));
    @(negedge clk);

    // Single read from port 0: grant after one cycle, data one cycle later.
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 12'h010, '0);
    #1;
    check("t1_gnt_c0", 32'(m0_gnt), 32'(0));
    cycle();
    #1;
    check("t1_gnt_c1", 32'(m0_gnt), 32'(1));
    check("t1_rd_en_c1", 32'(ram_rd_en), 32'(1));
    check("t1_addr_c1", 32'(ram_addr), 32'(12'h010));
    cycle();
    check("t1_rvalid_c2", 32'(m0_rvalid), 32'(1));
    check("t1_rdata_c2", 32'(rdata), 32'(init_val(16)));
    drive(0, 1'b0, 1'b0, '0, '0);
    cycle();
    check("t1_released", 32'(m0_gnt), 32'(0));

    // Simultaneous requests from reset favour port 0, then alternate.
    apply_reset();
    drive(0, 1'b1, 1'b0, 12'h020, '0);
    drive(1, 1'b1, 1'b0, 12'h030, '0);
    cycle();
    check("t2_first_m0", 32'(m0_gnt), 32'(1));
    check("t2_first_m1", 32'(m1_gnt), 32'(0));
    drive(0, 1'b0, 1'b0, 12'h020, '0);
    cycle();
    check("t2_idle_gnt", 32'({m0_gnt, m1_gnt}), 32'(0));
    drive(0, 1'b1, 1'b0, 12'h020, '0);
    cycle();
    check("t2_rr_m1", 32'(m1_gnt), 32'(1));
    check("t2_rr_m0", 32'(m0_gnt), 32'(0));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cycle();

    // Port 0 streams 8 writes while port 1 waits; handover with no idle bubble.
    drive(0, 1'b1, 1'b1, 12'h100, 16'h00A0);
    drive(1, 1'b1, 1'b0, 12'h100, '0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      check("t3_m0_gnt", 32'(m0_gnt), 32'(1));
      check("t3_m1_wait", 32'(m1_gnt), 32'(0));
      drive(0, 1'b1, 1'b1, 12'h100 + AW'(i), 16'h00A0 + DW'(i));
      cycle();
    end
    check("t3_handover_m0", 32'(m0_gnt), 32'(0));
    check("t3_handover_m1", 32'(m1_gnt), 32'(1));
    for (int i = 0; i < 8; i++) begin
      check("t3_m1_gnt", 32'(m1_gnt), 32'(1));
      drive(1, 1'b1, 1'b0, 12'h100 + AW'(i), '0);
      cycle();
    end
    check("t3_regrant_m0", 32'(m0_gnt), 32'(1));
    check("t3_late_rvalid", 32'(m1_rvalid), 32'(1));
    check("t3_late_rdata", 32'(rdata), 32'(16'h00A7));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      check("t3_mem", 32'(ram_mem[12'h100 + AW'(i)]), 32'(16'h00A0 + DW'(i)));
    end

    // Port 1 alone holds past the limit: no preemption, every read answered.
    drive(1, 1'b1, 1'b0, 12'h040, '0);
    cycle();
    rv_start = rv_count[1];
    for (int k = 0; k < 20; k++) begin
      check("t4_m1_gnt", 32'(m1_gnt), 32'(1));
      check("t4_m0_gnt", 32'(m0_gnt), 32'(0));
      drive(1, 1'b1, 1'b0, 12'h040 + AW'(k), '0);
      cycle();
    end
    check("t4_still_owner", 32'(m1_gnt), 32'(1));
    drive(1, 1'b0, 1'b0, '0, '0);
    cycle();
    check("t4_rvalid_count", 32'(rv_count[1] - rv_start), 32'(20));
    check("t4_released", 32'(m1_gnt), 32'(0));

    // Reset lands while a read is in flight: the read is dropped.
    drive(0, 1'b1, 1'b0, 12'h055, '0);
    cycle();
    check("t5_gnt", 32'(m0_gnt), 32'(1));
    #1;
    check("t5_rd_issue", 32'(ram_rd_en), 32'(1));
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("t5_gnt_async", 32'({m0_gnt, m1_gnt}), 32'(0));
    check("t5_rd_async", 32'(ram_rd_en), 32'(0));
    @(negedge clk);
    check("t5_rvalid", 32'(m0_rvalid), 32'(0));
    check("t5_rdata", 32'(rdata), 32'(0));
    check("t5_ram_en", 32'({ram_wr_en, ram_rd_en}), 32'(0));
    drive(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    cycle();
    check("t5_rvalid_after", 32'(m0_rvalid), 32'(0));

    // Random interleaved traffic on a small address window.
    for (int n = 0; n < 400; n++) begin
      drive(0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            12'h300 + AW'($urandom_range(0, 15)), DW'($urandom));
      drive(1, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            12'h300 + AW'($urandom_range(0, 15)), DW'($urandom));
      cycle();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cycle();
    cycle();
    check("t6_sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
